sr_cmd_recover: RTL

- Receive side of the SR-to-T conversion path. Set/reset intent is encoded as per-bit toggle words that drive a bank of T flip-flops.
- This block observes the toggle-word stream and tracks a shadow copy of the T-flop bank state. From each toggle word it recovers the equivalent per-bit S/R command.
- Recovered commands are buffered in a small FIFO and handed downstream over a valid/ready handshake.

---
 rtl/sr_cmd_recover.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sr_cmd_recover.sv
// Turns a toggle-word stream into per-bit S/R commands against a shadow T-flop bank, queued for a valid/ready consumer.
// A word accepted at edge N is at the head after edge N; t_ready drops while the queue is full (registered, no pass-through).

module sr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_rdy & ~empty;
  assign push_rdy = ~full;
  assign pop_vld  = ~empty;
  // Head reads as zero when nothing is queued.
  assign pop_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module sr_cmd_recover #(
  parameter int W         = 4,
  parameter int DEPTH     = 4,
  parameter bit DROP_HOLD = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] t_in,
  input  logic         t_valid,
  output logic         t_ready,
  output logic [W-1:0] s_out,
  output logic [W-1:0] r_out,
  output logic [W-1:0] q_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q_shadow,
  output logic [15:0]  toggle_cnt,
  output logic         overflow
);
  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
  } cmd_t;

  cmd_t push_dat;
  cmd_t head_dat;
  logic accept;
  logic hold;
  logic push_vld;

  assign accept   = t_valid & t_ready;
  assign hold     = (t_in == '0);
  // With DROP_HOLD an all-zero word is still accepted, it just never reaches the queue.
  assign push_vld = accept & ~(DROP_HOLD & hold);

  assign push_dat.s = t_in & ~q_shadow;
  assign push_dat.r = t_in & q_shadow;
  assign push_dat.q = q_shadow ^ t_in;

  sr_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (t_ready),
    .pop_vld  (out_valid),
    .pop_dat  (head_dat),
    .pop_rdy  (out_ready)
  );

  assign s_out = head_dat.s;
  assign r_out = head_dat.r;
  assign q_out = head_dat.q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_shadow   <= '0;
      toggle_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) q_shadow <= push_dat.q;
      if (accept && !hold && toggle_cnt != 16'hFFFF) toggle_cnt <= toggle_cnt + 16'd1;
      if (t_valid && !t_ready) overflow <= 1'b1;
    end
  end
endmodule
